// File: rtl/key_debounce_top.sv
// Channel index mapping for the key pair; the top module lives in rtl/key_pair_debouncer.sv.
package key_debounce_top_pkg;
  localparam int unsigned KEY1_IDX = 0;
  localparam int unsigned KEY2_IDX = 1;
endpackage

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and the default
// debounce length for a 50 MHz clock.
package key_pkg;

  typedef enum logic [1:0] {
    REL_STABLE = 2'b00,
    PRESS_WAIT = 2'b01,
    PRS_STABLE = 2'b10,
    REL_WAIT   = 2'b11
  } key_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;  // 10 ms @ 50 MHz
  localparam int unsigned CNT_W_DEF           = 20;
  localparam int unsigned NUM_KEYS            = 2;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchronizer feeding a bounce-rejecting FSM with a
// saturating stability counter. Outputs are registered level and edge pulses.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic db_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             db_q, press_q, rls_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Counter only advances in the WAIT states and is cleared on every state entry,
  // so it can never pass CNT_MAX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= REL_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rls_q   <= 1'b0;
      case (state_q)
        REL_STABLE: if (!s2_q) begin
          state_q <= PRESS_WAIT;
          cnt_q   <= '0;
        end
        PRESS_WAIT: begin
          if (s2_q) begin
            state_q <= REL_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= PRS_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRS_STABLE: if (s2_q) begin
          state_q <= REL_WAIT;
          cnt_q   <= '0;
        end
        REL_WAIT: begin
          if (!s2_q) begin
            state_q <= PRS_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= REL_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b1;
            rls_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= REL_STABLE;
          cnt_q   <= '0;
          db_q    <= 1'b1;
        end
      endcase
    end
  end

  assign db_o      = db_q;
  assign press_o   = press_q;
  assign release_o = rls_q;

endmodule

// File: rtl/key_pair_debouncer.sv
// Debounces the active-low KEY1/KEY2 pair for the speed-counter FSM; each key is an
// independent channel, and the top only adds the both-released AND.
module key_pair_debouncer
  import key_pkg::*;
  import key_debounce_top_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic areset,
  input  logic key1_raw,
  input  logic key2_raw,
  output logic key1_db,
  output logic key2_db,
  output logic key1_press,
  output logic key2_press,
  output logic key1_release,
  output logic key2_release,
  output logic both_released
);

  logic [NUM_KEYS-1:0] raw_w, db_w, press_w, rls_w;

  assign raw_w = {key2_raw, key1_raw};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk_i    (clock),
      .rst_i    (areset),
      .raw_i    (raw_w[k]),
      .db_o     (db_w[k]),
      .press_o  (press_w[k]),
      .release_o(rls_w[k])
    );
  end

  assign key1_db       = db_w[KEY1_IDX];
  assign key2_db       = db_w[KEY2_IDX];
  assign key1_press    = press_w[KEY1_IDX];
  assign key2_press    = press_w[KEY2_IDX];
  assign key1_release  = rls_w[KEY1_IDX];
  assign key2_release  = rls_w[KEY2_IDX];
  assign both_released = &db_w;

endmodule

// File: tb/tb_key_pair_debouncer.sv
// Directed bench for key_pair_debouncer (D=4): stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_key_pair_debouncer;

  logic clock = 1'b0;
  logic areset, key1_raw, key2_raw;
  logic key1_db, key2_db, key1_press, key2_press;
  logic key1_release, key2_release, both_released;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n0, m0;

  // kind: 0 key1_press, 1 key2_press, 2 key1_release, 3 key2_release
  typedef struct {
    int   kind;
    int   cyc;
    logic db1;
    logic db2;
    logic both;
  } ev_t;
  ev_t q[$];
  ev_t e;
  logic [3:0] pv;

  key_pair_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock        (clock),
    .areset       (areset),
    .key1_raw     (key1_raw),
    .key2_raw     (key2_raw),
    .key1_db      (key1_db),
    .key2_db      (key2_db),
    .key1_press   (key1_press),
    .key2_press   (key2_press),
    .key1_release (key1_release),
    .key2_release (key2_release),
    .both_released(both_released)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    pv = {key2_release, key1_release, key2_press, key1_press};
    for (int k = 0; k < 4; k++) begin
      if (pv[k]) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse kind=%0d cyc=%0d (no event expected)", k, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != k || e.cyc != cyc || key1_db !== e.db1 ||
              key2_db !== e.db2 || both_released !== e.both) begin
            failures++;
            $display("FAIL pulse_event got kind=%0d cyc=%0d db1=%b db2=%b both=%b want kind=%0d cyc=%0d db1=%b db2=%b both=%b",
                     k, cyc, key1_db, key2_db, both_released,
                     e.kind, e.cyc, e.db1, e.db2, e.both);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input logic d1, input logic d2, input logic b);
    ev_t x;
    x.kind = kind; x.cyc = at; x.db1 = d1; x.db2 = d2; x.both = b;
    q.push_back(x);
  endtask

  initial begin
    areset = 1'b1; key1_raw = 1'b1; key2_raw = 1'b1;
    step(3);
    chk("rst_key1_db", int'(key1_db), 1);
    chk("rst_key2_db", int'(key2_db), 1);
    chk("rst_both", int'(both_released), 1);
    chk("rst_pulses", int'({key1_press, key2_press, key1_release, key2_release}), 0);
    areset = 1'b0;
    step(3);

    // reset lands mid-PRESS_WAIT (cnt=2), raw stays low through it
    key1_raw = 1'b0; n0 = cyc;
    step(5);
    #2 areset = 1'b1;
    #1;
    chk("midrst_key1_db", int'(key1_db), 1);
    chk("midrst_pulses", int'({key1_press, key2_press, key1_release, key2_release}), 0);
    chk("midrst_both", int'(both_released), 1);
    step(3);
    areset = 1'b0; m0 = cyc;
    push(0, m0 + 7, 1'b0, 1'b1, 1'b0);
    step(12);
    key1_raw = 1'b1;
    push(2, cyc + 7, 1'b1, 1'b1, 1'b1);
    step(12);

    // clean press, then release
    key1_raw = 1'b0;
    push(0, cyc + 7, 1'b0, 1'b1, 1'b0);
    step(12);
    chk("press_key1_db", int'(key1_db), 0);
    chk("press_key2_db", int'(key2_db), 1);
    key1_raw = 1'b1;
    push(2, cyc + 7, 1'b1, 1'b1, 1'b1);
    step(12);
    chk("rel_key1_db", int'(key1_db), 1);

    // bounce: low 3, high 1, low held; final low first sampled at n0+5
    n0 = cyc;
    key1_raw = 1'b0;
    step(3);
    key1_raw = 1'b1;
    step(1);
    key1_raw = 1'b0;
    push(0, n0 + 11, 1'b0, 1'b1, 1'b0);
    step(15);
    key1_raw = 1'b1;
    push(2, cyc + 7, 1'b1, 1'b1, 1'b1);
    step(12);

    // glitch on key2: two low samples only
    key2_raw = 1'b0;
    step(2);
    key2_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_key2_db", int'(key2_db), 1);
    end

    // simultaneous press and release
    key1_raw = 1'b0; key2_raw = 1'b0;
    push(0, cyc + 7, 1'b0, 1'b0, 1'b0);
    push(1, cyc + 7, 1'b0, 1'b0, 1'b0);
    step(12);
    chk("sim_both_low", int'(both_released), 0);
    key1_raw = 1'b1; key2_raw = 1'b1;
    push(2, cyc + 7, 1'b1, 1'b1, 1'b1);
    push(3, cyc + 7, 1'b1, 1'b1, 1'b1);
    step(12);
    chk("sim_both_rel", int'(both_released), 1);

    chk("events_left", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
